// File: rtl/axi_lite_xbar_n.sv
// axi_lite_xbar_n: 1-master to NS-slave AXI-Lite crossbar.
// Targets are decoded by mask/base. Unmapped addresses are answered locally with DECERR.
// Only one transaction is outstanding at a time. When read and write requests arrive
// together, the two channels are granted alternately.
module axi_lite_xbar_n #(
    parameter int              NS       = 2,
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [NS*AW-1:0] SLV_BASE = {32'h80000000, 32'h02000000},
    parameter logic [NS*AW-1:0] SLV_MASK = {32'hF8000000, 32'hFFFF0000}
) (
    input  logic                 clk,
    input  logic                 rst,
    // master-side AR / R
    input  logic [AW-1:0]        s_araddr,
    input  logic                 s_arvalid,
    output logic                 s_arready,
    output logic [DW-1:0]        s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 s_rvalid,
    input  logic                 s_rready,
    // master-side AW / W / B
    input  logic [AW-1:0]        s_awaddr,
    input  logic                 s_awvalid,
    output logic                 s_awready,
    input  logic [DW-1:0]        s_wdata,
    input  logic [DW/8-1:0]      s_wstrb,
    input  logic                 s_wvalid,
    output logic                 s_wready,
    output logic [1:0]           s_bresp,
    output logic                 s_bvalid,
    input  logic                 s_bready,
    // slave side (address and write data are broadcast)
    output logic [AW-1:0]        m_araddr,
    output logic [AW-1:0]        m_awaddr,
    output logic [DW-1:0]        m_wdata,
    output logic [DW/8-1:0]      m_wstrb,
    output logic [NS-1:0]        m_arvalid,
    output logic [NS-1:0]        m_awvalid,
    output logic [NS-1:0]        m_wvalid,
    input  logic [NS-1:0]        m_arready,
    input  logic [NS-1:0]        m_awready,
    input  logic [NS-1:0]        m_wready,
    input  logic [NS*DW-1:0]     m_rdata,
    input  logic [NS*2-1:0]      m_rresp,
    input  logic [NS*2-1:0]      m_bresp,
    input  logic [NS-1:0]        m_rvalid,
    input  logic [NS-1:0]        m_bvalid,
    output logic [NS-1:0]        m_rready,
    output logic [NS-1:0]        m_bready
);

    localparam int   SW      = (NS > 1) ? $clog2(NS) : 1;
    localparam logic PRIO_RD = 1'b0;
    localparam logic PRIO_WR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;
    logic [SW-1:0] r_sel;
    logic [SW-1:0] w_sel_nx;
    logic          r_err;
    logic          w_err_nx;
    logic          r_aw_done;
    logic          w_aw_done_nx;
    logic          r_w_done;
    logic          w_w_done_nx;
    logic          r_prio;
    logic          w_prio_nx;
    logic [SW:0]   w_dec_rd;
    logic [SW:0]   w_dec_wr;

    // Returns {miss, index}. The loop runs downward so the lowest hitting slave wins.
    function automatic logic [SW:0] decode(input logic [AW-1:0] addr);
        logic [SW:0] res;
        res = {1'b1, {SW{1'b0}}};
        for (int i = NS - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                res = {1'b0, SW'(i)};
            end
        end
        return res;
    endfunction

    assign w_dec_rd = decode(s_araddr);
    assign w_dec_wr = decode(s_awaddr);

    assign m_araddr = s_araddr;
    assign m_awaddr = s_awaddr;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;

    // State, target selection and arbitration registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_sel     <= {SW{1'b0}};
            r_err     <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_prio    <= PRIO_RD;
        end else begin
            r_state   <= w_state_nx;
            r_sel     <= w_sel_nx;
            r_err     <= w_err_nx;
            r_aw_done <= w_aw_done_nx;
            r_w_done  <= w_w_done_nx;
            r_prio    <= w_prio_nx;
        end
    end

    // Next state and channel routing. The registered target alone steers the handshakes.
    always_comb begin
        w_state_nx   = r_state;
        w_sel_nx     = r_sel;
        w_err_nx     = r_err;
        w_aw_done_nx = r_aw_done;
        w_w_done_nx  = r_w_done;
        w_prio_nx    = r_prio;
        s_arready    = 1'b0;
        s_rvalid     = 1'b0;
        s_rdata      = {DW{1'b0}};
        s_rresp      = 2'b00;
        s_awready    = 1'b0;
        s_wready     = 1'b0;
        s_bvalid     = 1'b0;
        s_bresp      = 2'b00;
        m_arvalid    = {NS{1'b0}};
        m_awvalid    = {NS{1'b0}};
        m_wvalid     = {NS{1'b0}};
        m_rready     = {NS{1'b0}};
        m_bready     = {NS{1'b0}};
        case (r_state)
            ST_IDLE: begin
                // A bubble cycle: only the grant is decided here, nothing handshakes.
                if (s_arvalid && (!s_awvalid || (r_prio == PRIO_RD))) begin
                    w_state_nx = ST_RD_REQ;
                    w_sel_nx   = w_dec_rd[SW-1:0];
                    w_err_nx   = w_dec_rd[SW];
                    if (s_awvalid) begin
                        w_prio_nx = PRIO_WR;
                    end else begin
                        w_prio_nx = r_prio;
                    end
                end else if (s_awvalid) begin
                    w_state_nx = ST_WR_REQ;
                    w_sel_nx   = w_dec_wr[SW-1:0];
                    w_err_nx   = w_dec_wr[SW];
                    if (s_arvalid) begin
                        w_prio_nx = PRIO_RD;
                    end else begin
                        w_prio_nx = r_prio;
                    end
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (r_err) begin
                    s_arready = 1'b1;
                end else begin
                    m_arvalid[r_sel] = s_arvalid;
                    s_arready        = m_arready[r_sel];
                end
                if (s_arvalid && s_arready) begin
                    w_state_nx = ST_RD_RESP;
                end else begin
                    w_state_nx = ST_RD_REQ;
                end
            end
            ST_RD_RESP: begin
                if (r_err) begin
                    s_rvalid = 1'b1;
                    s_rdata  = {DW{1'b0}};
                    s_rresp  = 2'b11;
                end else begin
                    s_rvalid        = m_rvalid[r_sel];
                    s_rdata         = m_rdata[r_sel*DW +: DW];
                    s_rresp         = m_rresp[r_sel*2 +: 2];
                    m_rready[r_sel] = s_rready;
                end
                if (s_rvalid && s_rready) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_RD_RESP;
                end
            end
            ST_WR_REQ: begin
                // A channel that has already handshaken is masked so it cannot be accepted twice.
                if (!r_aw_done) begin
                    if (r_err) begin
                        s_awready = 1'b1;
                    end else begin
                        m_awvalid[r_sel] = s_awvalid;
                        s_awready        = m_awready[r_sel];
                    end
                end else begin
                    s_awready = 1'b0;
                end
                if (!r_w_done) begin
                    if (r_err) begin
                        s_wready = 1'b1;
                    end else begin
                        m_wvalid[r_sel] = s_wvalid;
                        s_wready        = m_wready[r_sel];
                    end
                end else begin
                    s_wready = 1'b0;
                end
                w_aw_done_nx = r_aw_done | (s_awvalid & s_awready);
                w_w_done_nx  = r_w_done | (s_wvalid & s_wready);
                if (w_aw_done_nx && w_w_done_nx) begin
                    w_state_nx   = ST_WR_RESP;
                    w_aw_done_nx = 1'b0;
                    w_w_done_nx  = 1'b0;
                end else begin
                    w_state_nx = ST_WR_REQ;
                end
            end
            ST_WR_RESP: begin
                if (r_err) begin
                    s_bvalid = 1'b1;
                    s_bresp  = 2'b11;
                end else begin
                    s_bvalid        = m_bvalid[r_sel];
                    s_bresp         = m_bresp[r_sel*2 +: 2];
                    m_bready[r_sel] = s_bready;
                end
                if (s_bvalid && s_bready) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_WR_RESP;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

endmodule
